// File: rtl/fp_mult_seq_param.sv
// Sequential floating-point multiplier with parametrised exponent/fraction widths.
// The significand product is built by a radix-2 shift-add loop, then normalised and rounded to nearest even.
module fp_mult_seq_param #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [EXP_W+MAN_W:0] a_in,
    input  logic [EXP_W+MAN_W:0] b_in,
    output logic [EXP_W+MAN_W:0] result,
    output logic                 done,
    output logic                 busy,
    output logic                 overflow,
    output logic                 underflow,
    output logic                 invalid
);

    localparam int W  = 1 + EXP_W + MAN_W;
    localparam int PW = 2 * MAN_W + 2;
    localparam int EW = EXP_W + 2;
    localparam int CW = $clog2(MAN_W + 1);

    localparam logic signed [EW-1:0] BIAS_E  = EW'((2 ** (EXP_W - 1)) - 1);
    localparam logic signed [EW-1:0] EXP_MAX = EW'((2 ** EXP_W) - 1);
    localparam logic signed [EW-1:0] ONE_E   = EW'(1);
    localparam logic signed [EW-1:0] ZERO_E  = EW'(0);
    localparam logic [CW-1:0]        CNT_INIT = CW'(MAN_W);

    typedef enum logic [2:0] {
        S_IDLE,
        S_MUL,
        S_NORM,
        S_RND,
        S_DONE
    } state_t;

    typedef enum logic [1:0] {
        K_NORMAL,
        K_ZERO,
        K_INF,
        K_NAN
    } kind_t;

    state_t                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [PW-1:0]         mcand_q, mcand_d;
    logic [MAN_W:0]        mplier_q, mplier_d;
    logic [PW-1:0]         prod_q, prod_d;
    logic signed [EW-1:0]  exp_q, exp_d;
    logic                  sign_q, sign_d;
    kind_t                 kind_q, kind_d;
    logic [W-1:0]          result_q, result_d;
    logic                  ovf_q, ovf_d;
    logic                  unf_q, unf_d;
    logic                  inv_q, inv_d;

    // Operand classification happens at accept time; the class rides along with the op.
    logic [EXP_W-1:0]      ea, eb;
    logic [MAN_W-1:0]      fa, fb;
    logic                  a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
    kind_t                 kind_in;
    logic signed [EW-1:0]  exp_in;
    logic                  accept;

    assign ea = a_in[MAN_W +: EXP_W];
    assign eb = b_in[MAN_W +: EXP_W];
    assign fa = a_in[MAN_W-1:0];
    assign fb = b_in[MAN_W-1:0];

    assign a_zero = (ea == '0);
    assign b_zero = (eb == '0);
    assign a_inf  = (&ea) && (fa == '0);
    assign b_inf  = (&eb) && (fb == '0);
    assign a_nan  = (&ea) && (fa != '0);
    assign b_nan  = (&eb) && (fb != '0);

    always_comb begin
        kind_in = K_NORMAL;
        if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) begin
            kind_in = K_NAN;
        end else if (a_inf || b_inf) begin
            kind_in = K_INF;
        end else if (a_zero || b_zero) begin
            kind_in = K_ZERO;
        end
    end

    assign exp_in = $signed({2'b00, ea}) + $signed({2'b00, eb}) - BIAS_E;
    assign accept = start && ((state_q == S_IDLE) || (state_q == S_DONE));

    // After NORM the leading one sits at prod_q[PW-1]; keep MAN_W+1 bits, guard below, sticky under that.
    logic [MAN_W:0]        kept;
    logic                  guard, sticky, round_up, carry;
    logic [MAN_W+1:0]      rsum;
    logic [MAN_W-1:0]      frac_rnd;
    logic signed [EW-1:0]  exp_fin;

    assign kept     = prod_q[PW-1 -: MAN_W+1];
    assign guard    = prod_q[MAN_W];
    assign sticky   = |prod_q[MAN_W-1:0];
    assign round_up = guard && (sticky || kept[0]);
    assign rsum     = {1'b0, kept} + {{(MAN_W+1){1'b0}}, round_up};
    assign carry    = rsum[MAN_W+1];
    assign frac_rnd = carry ? rsum[MAN_W:1] : rsum[MAN_W-1:0];
    assign exp_fin  = exp_q + $signed({{(EW-1){1'b0}}, carry});

    logic [W-1:0] qnan_word, inf_word, zero_word;

    assign qnan_word = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
    assign inf_word  = {sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    assign zero_word = {sign_q, {(W-1){1'b0}}};

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        prod_d   = prod_q;
        exp_d    = exp_q;
        sign_d   = sign_q;
        kind_d   = kind_q;
        result_d = result_q;
        ovf_d    = ovf_q;
        unf_d    = unf_q;
        inv_d    = inv_q;

        case (state_q)
            S_IDLE: begin
                state_d = S_IDLE;
            end
            S_MUL: begin
                prod_d   = prod_q + (mplier_q[0] ? mcand_q : {PW{1'b0}});
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q - CW'(1);
                if (cnt_q == '0) begin
                    state_d = S_NORM;
                end
            end
            S_NORM: begin
                if (prod_q[PW-1]) begin
                    exp_d = exp_q + ONE_E;
                end else begin
                    prod_d = prod_q << 1;
                end
                state_d = S_RND;
            end
            S_RND: begin
                ovf_d = 1'b0;
                unf_d = 1'b0;
                inv_d = 1'b0;
                case (kind_q)
                    K_NAN: begin
                        result_d = qnan_word;
                        inv_d    = 1'b1;
                    end
                    K_INF: begin
                        result_d = inf_word;
                    end
                    K_ZERO: begin
                        result_d = zero_word;
                    end
                    default: begin
                        if (exp_fin >= EXP_MAX) begin
                            result_d = inf_word;
                            ovf_d    = 1'b1;
                        end else if (exp_fin <= ZERO_E) begin
                            result_d = zero_word;
                            unf_d    = 1'b1;
                        end else begin
                            result_d = {sign_q, exp_fin[EXP_W-1:0], frac_rnd};
                        end
                    end
                endcase
                state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // DONE also accepts, so a new op can follow the done pulse with no gap.
        if (accept) begin
            state_d  = S_MUL;
            cnt_d    = CNT_INIT;
            mcand_d  = {{(MAN_W+1){1'b0}}, 1'b1, fa};
            mplier_d = {1'b1, fb};
            prod_d   = '0;
            exp_d    = exp_in;
            sign_d   = a_in[W-1] ^ b_in[W-1];
            kind_d   = kind_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            prod_q   <= '0;
            exp_q    <= '0;
            sign_q   <= 1'b0;
            kind_q   <= K_NORMAL;
            result_q <= '0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
            inv_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            prod_q   <= prod_d;
            exp_q    <= exp_d;
            sign_q   <= sign_d;
            kind_q   <= kind_d;
            result_q <= result_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
            inv_q    <= inv_d;
        end
    end

    assign result    = result_q;
    assign overflow  = ovf_q;
    assign underflow = unf_q;
    assign invalid   = inv_q;
    assign done      = (state_q == S_DONE);
    assign busy      = (state_q == S_MUL) || (state_q == S_NORM) || (state_q == S_RND);

endmodule
